// File: rtl/hazard_pkg.sv
// Shared MIPS opcode/function encodings, scoreboard slot layout and forwarding
// select codes for the ID-stage hazard unit.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL     = 6'd0;
  localparam logic [5:0] FN_SRL     = 6'd2;
  localparam logic [5:0] FN_SRA     = 6'd3;
  localparam logic [5:0] FN_SLLV    = 6'd4;
  localparam logic [5:0] FN_SRLV    = 6'd6;
  localparam logic [5:0] FN_SRAV    = 6'd7;
  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_SYSCALL = 6'd12;
  localparam logic [5:0] FN_MULT    = 6'd24;
  localparam logic [5:0] FN_MULTU   = 6'd25;
  localparam logic [5:0] FN_DIV     = 6'd26;
  localparam logic [5:0] FN_DIVU    = 6'd27;
  localparam logic [5:0] FN_ADD     = 6'd32;
  localparam logic [5:0] FN_ADDU    = 6'd33;
  localparam logic [5:0] FN_SUB     = 6'd34;
  localparam logic [5:0] FN_AND     = 6'd36;
  localparam logic [5:0] FN_OR      = 6'd37;
  localparam logic [5:0] FN_NOR     = 6'd39;
  localparam logic [5:0] FN_SLT     = 6'd42;
  localparam logic [5:0] FN_SLTU    = 6'd43;

  // Slot register field is sized for the widest supported register file;
  // narrower addresses are zero-extended on entry and on compare.
  localparam int unsigned SB_RW = 8;
  localparam int unsigned MC_CW = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic [SB_RW-1:0] rd;
    logic             is_load;
  } slot_t;

  function automatic fwd_sel_e slot_fwd(input int unsigned idx, input int unsigned stages);
    if (idx == 0) return FWD_EX;
    if (idx == stages - 1) return FWD_WB;
    return FWD_MEM;
  endfunction

endpackage

// File: rtl/reg_usage_decode.sv
// Combinational decode of which GPR source fields (rs/rt) an instruction reads.
module reg_usage_decode
  import hazard_pkg::*;
#(
  parameter bit EXT_DECODE = 1'b1
) (
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output logic       r1_used_o,
  output logic       r2_used_o
);

  always_comb begin
    r1_used_o = 1'b0;
    r2_used_o = 1'b0;
    if (op_i == OP_RTYPE) begin
      case (func_i)
        FN_JR: r1_used_o = 1'b1;
        FN_SLL, FN_SRL, FN_SRA: r2_used_o = 1'b1;
        FN_SYSCALL, FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: begin
          r1_used_o = 1'b1;
          r2_used_o = 1'b1;
        end
        FN_SLLV, FN_SRLV, FN_SRAV, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
          r1_used_o = EXT_DECODE;
          r2_used_o = EXT_DECODE;
        end
        default: ;
      endcase
    end else begin
      case (op_i)
        OP_BEQ, OP_BNE, OP_SW: begin
          r1_used_o = 1'b1;
          r2_used_o = 1'b1;
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: r1_used_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stateful hazard unit beside ID: tracks in-flight destinations through EX..WB
// and one multi-cycle unit, producing stall and per-operand forwarding selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MC_LAT     = 4,
  parameter bit          EXT_DECODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              flush,
  output logic              r1_used,
  output logic              r2_used,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mc_busy
);

  localparam int unsigned WB = STAGES - 1;

  slot_t             slots_q [STAGES];
  slot_t             slots_d [STAGES];
  slot_t             mc_entry;
  logic [MC_CW-1:0]  mc_cnt_q, mc_cnt_d;
  logic [REG_AW-1:0] mc_reg_q, mc_reg_d;
  logic              mc_trk_q, mc_trk_d;
  logic              mc_pend_q, mc_pend_d;

  logic     dec_r1, dec_r2;
  logic     use_a, use_b;
  logic     lu_a, lu_b;
  logic     mc_hit, mc_busy_w, stall_w;
  logic     ex_load, issue_mc;
  fwd_sel_e fwd_a, fwd_b;

  reg_usage_decode #(
    .EXT_DECODE(EXT_DECODE)
  ) u_decode (
    .op_i      (id_op),
    .func_i    (id_func),
    .r1_used_o (dec_r1),
    .r2_used_o (dec_r2)
  );

  always_comb begin
    use_a = id_valid & dec_r1 & (id_rs != '0);
    use_b = id_valid & dec_r2 & (id_rt != '0);
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    // Walk oldest to youngest so the youngest matching slot is the one that sticks.
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (use_a && slots_q[WB-i].valid && slots_q[WB-i].rd == SB_RW'(id_rs)) begin
        fwd_a = slot_fwd(WB - i, STAGES);
        lu_a  = (WB - i == 0) && slots_q[WB-i].is_load;
      end
      if (use_b && slots_q[WB-i].valid && slots_q[WB-i].rd == SB_RW'(id_rt)) begin
        fwd_b = slot_fwd(WB - i, STAGES);
        lu_b  = (WB - i == 0) && slots_q[WB-i].is_load;
      end
    end
    if (lu_a) fwd_a = FWD_RF;
    if (lu_b) fwd_b = FWD_RF;

    mc_busy_w = (mc_cnt_q != '0) | mc_pend_q;
    mc_hit    = mc_busy_w & mc_trk_q &
                ((use_a & (id_rs == mc_reg_q)) | (use_b & (id_rt == mc_reg_q)));
    stall_w   = id_valid & ~flush & (lu_a | lu_b | mc_hit | (id_is_mc & mc_busy_w));
  end

  always_comb begin
    ex_load  = id_valid & id_wr_en & (id_wr_reg != '0) & ~stall_w & ~flush & ~id_is_mc;
    issue_mc = id_valid & id_is_mc & ~stall_w & ~flush;

    slots_d[0].valid   = ex_load;
    slots_d[0].rd      = ex_load ? SB_RW'(id_wr_reg) : '0;
    slots_d[0].is_load = ex_load & id_is_load;
    for (int unsigned i = 1; i < STAGES; i++) begin
      slots_d[i] = slots_q[i-1];
    end

    mc_entry.valid   = 1'b1;
    mc_entry.rd      = SB_RW'(mc_reg_q);
    mc_entry.is_load = 1'b0;

    // A completing result only claims WB over a bubble; otherwise it waits a cycle.
    mc_pend_d = 1'b0;
    if (mc_pend_q) begin
      slots_d[WB] = mc_entry;
    end else if (mc_trk_q && mc_cnt_q == MC_CW'(1)) begin
      if (slots_q[WB-1].valid) begin
        mc_pend_d = 1'b1;
      end else begin
        slots_d[WB] = mc_entry;
      end
    end

    mc_cnt_d = mc_cnt_q;
    mc_reg_d = mc_reg_q;
    mc_trk_d = mc_trk_q;
    if (issue_mc) begin
      mc_cnt_d = MC_CW'(MC_LAT);
      mc_reg_d = id_wr_reg;
      mc_trk_d = id_wr_en & (id_wr_reg != '0);
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - MC_CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        slots_q[i] <= '0;
      end
      mc_cnt_q  <= '0;
      mc_reg_q  <= '0;
      mc_trk_q  <= 1'b0;
      mc_pend_q <= 1'b0;
    end else begin
      slots_q   <= slots_d;
      mc_cnt_q  <= mc_cnt_d;
      mc_reg_q  <= mc_reg_d;
      mc_trk_q  <= mc_trk_d;
      mc_pend_q <= mc_pend_d;
    end
  end

  assign r1_used   = ~rst & id_valid & dec_r1;
  assign r2_used   = ~rst & id_valid & dec_r2;
  assign stall     = stall_w;
  assign fwd_a_sel = fwd_a;
  assign fwd_b_sel = fwd_b;
  assign mc_busy   = mc_busy_w;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios then random traffic,
// checked against an age-list reference model through an expectation queue.
module tb_hazard_scoreboard;

  localparam int unsigned STAGES = 3;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned MC_LAT = 4;
  localparam bit          EXT    = 1'b1;
  localparam int          WBI    = int'(STAGES) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [5:0]        id_op = '0;
  logic [5:0]        id_func = '0;
  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic              id_wr_en = 1'b0;
  logic [REG_AW-1:0] id_wr_reg = '0;
  logic              id_is_load = 1'b0;
  logic              id_is_mc = 1'b0;
  logic              flush = 1'b0;
  logic              r1_used, r2_used, stall, mc_busy;
  logic [1:0]        fwd_a_sel, fwd_b_sel;

  hazard_scoreboard #(
    .STAGES(STAGES), .REG_AW(REG_AW), .MC_LAT(MC_LAT), .EXT_DECODE(EXT)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .flush(flush),
    .r1_used(r1_used), .r2_used(r2_used), .stall(stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mc_busy(mc_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [5:0] op; logic [5:0] fn; logic [4:0] rs; logic [4:0] rt;
    logic we; logic [4:0] wr; logic ld; logic mc; logic fl;
  } ins_t;
  typedef struct packed {
    logic r1; logic r2; logic st; logic [1:0] fa; logic [1:0] fb; logic busy;
  } exp_t;
  typedef struct { int rd; bit ld; int age; } rec_t;

  // Reference state: destinations in flight with their age past ID, and the MC unit.
  rec_t  inflight[$];
  int    mc_left;
  int    mc_dst;
  bit    mc_has;
  bit    mc_wait;
  exp_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  ins_t  cur;
  bit    cur_rst;
  bit    cur_stall;

  function automatic bit reads_rs(logic [5:0] op, logic [5:0] fn);
    if (op == 6'd0)
      return (fn inside {6'd8, 6'd12, 6'd32, 6'd33, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd43}) ||
             (EXT && (fn inside {6'd4, 6'd6, 6'd7, 6'd24, 6'd25, 6'd26, 6'd27}));
    return op inside {6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43};
  endfunction

  function automatic bit reads_rt(logic [5:0] op, logic [5:0] fn);
    if (op == 6'd0)
      return (fn inside {6'd0, 6'd2, 6'd3, 6'd12, 6'd32, 6'd33, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd43}) ||
             (EXT && (fn inside {6'd4, 6'd6, 6'd7, 6'd24, 6'd25, 6'd26, 6'd27}));
    return op inside {6'd4, 6'd5, 6'd43};
  endfunction

  function automatic void model_clear();
    inflight.delete();
    mc_left = 0; mc_dst = 0; mc_has = 1'b0; mc_wait = 1'b0;
  endfunction

  function automatic void lookup(input int s, input bit u, output logic [1:0] f, output bit lu);
    int best;
    bit bl;
    best = -1; bl = 1'b0; f = 2'd0; lu = 1'b0;
    if (!u || s == 0) return;
    foreach (inflight[k])
      if (inflight[k].rd == s && (best < 0 || inflight[k].age < best)) begin
        best = inflight[k].age; bl = inflight[k].ld;
      end
    if (best < 0) return;
    if (best == 0) begin
      if (bl) lu = 1'b1; else f = 2'd1;
    end else if (best == WBI) f = 2'd3;
    else f = 2'd2;
  endfunction

  function automatic exp_t model_expect(ins_t n, bit r);
    exp_t e;
    bit u1, u2, la, lb, hit;
    logic [1:0] fa, fb;
    e = '0;
    if (r) return e;
    u1 = n.v && reads_rs(n.op, n.fn);
    u2 = n.v && reads_rt(n.op, n.fn);
    e.r1 = u1; e.r2 = u2;
    e.busy = (mc_left > 0) || mc_wait;
    lookup(int'(n.rs), u1, fa, la);
    lookup(int'(n.rt), u2, fb, lb);
    e.fa = fa; e.fb = fb;
    hit = e.busy && mc_has && ((u1 && n.rs != 0 && int'(n.rs) == mc_dst) ||
                               (u2 && n.rt != 0 && int'(n.rt) == mc_dst));
    e.st = n.v && !n.fl && (la || lb || hit || (n.mc && e.busy));
    return e;
  endfunction

  function automatic void model_edge(ins_t c, bit st);
    rec_t r;
    bit wb_taken;
    for (int k = inflight.size() - 1; k >= 0; k--) begin
      r = inflight[k];
      r.age = r.age + 1;
      if (r.age >= int'(STAGES)) inflight.delete(k);
      else inflight[k] = r;
    end
    if (c.v && c.we && c.wr != 0 && !st && !c.fl && !c.mc)
      inflight.push_back('{rd: int'(c.wr), ld: c.ld, age: 0});
    wb_taken = 1'b0;
    foreach (inflight[k]) if (inflight[k].age == WBI) wb_taken = 1'b1;
    if (mc_wait) begin
      for (int k = inflight.size() - 1; k >= 0; k--)
        if (inflight[k].age == WBI) inflight.delete(k);
      inflight.push_back('{rd: mc_dst, ld: 1'b0, age: WBI});
      mc_wait = 1'b0;
    end else if (mc_left == 1 && mc_has) begin
      if (wb_taken) mc_wait = 1'b1;
      else inflight.push_back('{rd: mc_dst, ld: 1'b0, age: WBI});
    end
    if (mc_left > 0) mc_left = mc_left - 1;
    if (c.v && c.mc && !st && !c.fl) begin
      mc_left = int'(MC_LAT);
      mc_dst  = int'(c.wr);
      mc_has  = c.we && c.wr != 0;
    end
  endfunction

  function automatic ins_t mk_r(int fn, int rd, int rs, int rt);
    ins_t i;
    i = '0; i.v = 1'b1; i.op = 6'd0; i.fn = 6'(fn);
    i.rs = 5'(rs); i.rt = 5'(rt); i.we = (fn != 8 && fn != 12); i.wr = 5'(rd);
    return i;
  endfunction

  function automatic ins_t mk_i(int op, int rt, int rs, bit ld);
    ins_t i;
    i = '0; i.v = 1'b1; i.op = 6'(op); i.rs = 5'(rs); i.rt = 5'(rt);
    i.we = (op != 4 && op != 5 && op != 43); i.wr = 5'(rt); i.ld = ld;
    return i;
  endfunction

  function automatic ins_t mk_mc(int fn, bit we, int wr, int rs, int rt);
    ins_t i;
    i = mk_r(fn, wr, rs, rt); i.we = we; i.mc = 1'b1;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int c;
    int rd, rs, rt;
    rd = int'($urandom_range(0, 7)); rs = int'($urandom_range(0, 7)); rt = int'($urandom_range(0, 7));
    c = int'($urandom_range(0, 10));
    case (c)
      0, 1, 2: i = mk_r(32 + int'($urandom_range(0, 11)), rd, rs, rt);
      3: i = mk_r(int'($urandom_range(0, 7)), rd, rs, rt);
      4: i = mk_i(35, rt, rs, 1'b1);
      5: i = mk_i(43, rt, rs, 1'b0);
      6: i = mk_i(8 + int'($urandom_range(0, 5)), rt, rs, 1'b0);
      7: begin i = mk_i(4 + int'($urandom_range(0, 1)), rt, rs, 1'b0); i.fl = 1'($urandom_range(0, 1)); end
      8: i = mk_mc(24 + int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), rd, rs, rt);
      9: i = mk_i(int'($urandom_range(0, 63)), rt, rs, 1'b0);
      default: begin i = mk_r(8, 0, rs, rt); i.v = 1'($urandom_range(0, 1)); end
    endcase
    if ($urandom_range(0, 15) == 0) i.fl = 1'b1;
    return i;
  endfunction

  task automatic step(input ins_t n, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    if (cur_rst) model_clear();
    else model_edge(cur, cur_stall);
    cur = n; cur_rst = r;
    rst = r; id_valid = n.v; id_op = n.op; id_func = n.fn; id_rs = n.rs; id_rt = n.rt;
    id_wr_en = n.we; id_wr_reg = n.wr; id_is_load = n.ld; id_is_mc = n.mc; flush = n.fl;
    if (r) model_clear();
    e = model_expect(n, r);
    cur_stall = e.st;
    exp_q.push_back(e);
  endtask

  task automatic run(input ins_t n);
    int guard;
    guard = 0;
    step(n, 1'b0);
    while (cur_stall && guard < 40) begin
      step(n, 1'b0);
      guard++;
    end
    if (cur_stall) begin
      tests++; fails++;
      $display("FAIL stall_bound: stall still %0d after %0d cycles, required 0", cur_stall, guard);
    end
  endtask

  task automatic chk(input string nm, input int act, input int ex);
    tests++;
    if (act != ex) begin
      fails++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, ex);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("r1_used", int'(r1_used), int'(e.r1));
        chk("r2_used", int'(r2_used), int'(e.r2));
        chk("stall", int'(stall), int'(e.st));
        chk("fwd_a_sel", int'(fwd_a_sel), int'(e.fa));
        chk("fwd_b_sel", int'(fwd_b_sel), int'(e.fb));
        chk("mc_busy", int'(mc_busy), int'(e.busy));
      end
    end
  end

  initial begin : driver
    ins_t nop;
    ins_t t;
    int   wait_cyc;
    nop = '0;
    cur = '0; cur_rst = 1'b1; cur_stall = 1'b0;
    model_clear();
    step(nop, 1'b1);
    step(nop, 1'b1);
    // Back-to-back dependency, then with one NOP between.
    run(mk_r(32, 3, 1, 2));  run(mk_r(34, 4, 3, 5));
    run(mk_r(32, 3, 1, 2));  run(nop); run(mk_r(34, 4, 3, 5));
    // Load-use, and store data from a load two slots back.
    run(mk_i(35, 8, 1, 1'b1)); run(mk_r(32, 9, 8, 2));
    run(mk_i(35, 8, 1, 1'b1)); run(nop); run(nop); run(mk_i(43, 8, 1, 1'b0));
    // $0 destination.
    run(mk_i(8, 0, 1, 1'b0)); run(mk_r(32, 2, 0, 0));
    // Multi-cycle dependency and back-to-back MC issue.
    run(mk_mc(24, 1'b1, 10, 1, 2)); run(mk_r(32, 11, 10, 1));
    run(mk_mc(26, 1'b1, 12, 3, 4)); run(mk_mc(27, 1'b1, 13, 5, 6)); run(mk_r(32, 14, 13, 12));
    // Flush over a load-use.
    run(mk_i(35, 8, 1, 1'b1));
    t = mk_r(32, 9, 8, 8); t.fl = 1'b1; run(t);
    run(mk_r(32, 1, 8, 2));
    // Reset with the MC counter at 2 and a load in EX.
    run(mk_mc(24, 1'b1, 10, 1, 2)); run(mk_r(32, 1, 2, 3)); run(mk_i(35, 8, 4, 1'b1));
    step(mk_r(32, 9, 8, 10), 1'b1);
    step(mk_r(32, 9, 8, 10), 1'b1);
    run(mk_r(32, 5, 6, 7)); run(mk_r(32, 9, 8, 10));
    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 79) == 0) step(rand_ins(), 1'b1);
      else run(rand_ins());
    end
    step(nop, 1'b0);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 5) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
